// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - mode-0 SPI master byte shift engine
// Shifts one byte out on mosi while capturing miso; start/busy/done handshake with optional cs hold.
module spi_byte_engine #(
   parameter int CLK_DIV   = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       keep_cs,
   input  logic       cs_release,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

   localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] phase;
   logic [7:0] tx_byte;
   logic [7:0] rx_shift;
   logic [2:0] bit_idx;
   logic       keep_cs_q;
   logic       phase_end;

   function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] i);
      return (MSB_FIRST != 0) ? b[3'd7 - i] : b[i];
   endfunction

   function automatic logic [7:0] rx_insert(input logic [7:0] r, input logic d);
      return (MSB_FIRST != 0) ? {r[6:0], d} : {d, r[7:1]};
   endfunction

   assign phase_end = (phase == PHASE_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         phase     <= '0;
         tx_byte   <= '0;
         rx_shift  <= '0;
         bit_idx   <= '0;
         keep_cs_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_data   <= '0;
         sclk      <= 1'b0;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            phase <= '0;
            // start outranks cs_release so a held frame can continue without a cs glitch
            if (start) begin
               tx_byte   <= tx_data;
               keep_cs_q <= keep_cs;
               busy      <= 1'b1;
               cs_n      <= 1'b0;
               mosi      <= tx_bit(tx_data, 3'd0);
               bit_idx   <= '0;
               state     <= LEAD;
            end else if (cs_release) begin
               cs_n <= 1'b1;
            end
         end else if (!phase_end) begin
            phase <= phase + 8'd1;
         end else begin
            phase <= '0;
            case (state)
               LEAD, LOW: begin
                  sclk     <= 1'b1;
                  rx_shift <= rx_insert(rx_shift, miso);
                  state    <= HIGH;
               end
               HIGH: begin
                  sclk <= 1'b0;
                  if (bit_idx == 3'd7) begin
                     state <= TRAIL;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     mosi    <= tx_bit(tx_byte, bit_idx + 3'd1);
                     state   <= LOW;
                  end
               end
               TRAIL: begin
                  rx_data <= rx_shift;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  mosi    <= 1'b0;
                  if (!keep_cs_q) cs_n <= 1'b1;
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb/tb_spi_byte_engine.sv - directed self-checking bench for spi_byte_engine
// Instance a: CLK_DIV=2 MSB first; instance b: CLK_DIV=1 LSB first.
module tb_spi_byte_engine;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic       start_a, keep_a, rel_a, busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
   logic [7:0] tx_a, rx_a;
   logic       start_b, keep_b, rel_b, busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;
   logic [7:0] tx_b, rx_b;
   logic [1:0] miso_mode;
   logic       mon_sel;

   int tests_run    = 0;
   int tests_failed = 0;

   assign miso_a = (miso_mode == 2'd2) ? mosi_a : miso_mode[0];
   assign miso_b = (miso_mode == 2'd2) ? mosi_b : miso_mode[0];

   spi_byte_engine #(.CLK_DIV(2), .MSB_FIRST(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .start(start_a), .tx_data(tx_a), .keep_cs(keep_a),
      .cs_release(rel_a), .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
      .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a));

   spi_byte_engine #(.CLK_DIV(1), .MSB_FIRST(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .start(start_b), .tx_data(tx_b), .keep_cs(keep_b),
      .cs_release(rel_b), .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
      .cs_n(cs_b), .mosi(mosi_b), .miso(miso_b));

   logic       m_busy, m_done, m_sclk, m_cs, m_mosi;
   logic [7:0] m_rx;
   assign m_busy = mon_sel ? busy_b : busy_a;
   assign m_done = mon_sel ? done_b : done_a;
   assign m_sclk = mon_sel ? sclk_b : sclk_a;
   assign m_cs   = mon_sel ? cs_b   : cs_a;
   assign m_mosi = mon_sel ? mosi_b : mosi_a;
   assign m_rx   = mon_sel ? rx_b   : rx_a;

   int         mon_busy, mon_nrise, mon_done_cnt, mon_done_c, mon_hi_chg, mon_cs_bad;
   int         mon_rise [0:15];
   logic [7:0] mon_mosi, mon_rx;
   logic       mon_cs_end;

   // Records one transfer; observation index c counts edges after the accepting edge.
   task automatic xfer(input logic s, input logic [7:0] tx, input logic kc, input int p1, input int p2);
      int   last;
      logic ps, pm;
      mon_sel = s;
      mon_busy = 0; mon_nrise = 0; mon_done_cnt = 0; mon_done_c = -1; mon_hi_chg = 0;
      mon_cs_bad = 0; mon_mosi = 8'h00; mon_rx = 8'h00;
      for (int k = 0; k < 16; k++) mon_rise[k] = -1;
      last = (s ? 17 : 34) + 2;
      @(negedge clock);
      if (s) begin start_b = 1'b1; tx_b = tx; keep_b = kc; end
      else   begin start_a = 1'b1; tx_a = tx; keep_a = kc; end
      ps = 1'b0;
      pm = 1'b0;
      for (int c = 0; c <= last; c++) begin
         @(negedge clock);
         if (m_busy) mon_busy++;
         if (m_busy && m_cs) mon_cs_bad++;
         if (m_sclk && !ps) begin
            if (mon_nrise < 16) mon_rise[mon_nrise] = c;
            mon_nrise++;
            mon_mosi = {mon_mosi[6:0], m_mosi};
         end
         if (m_sclk && ps && (m_mosi !== pm)) mon_hi_chg++;
         if (m_done) begin mon_done_cnt++; mon_done_c = c; mon_rx = m_rx; end
         mon_cs_end = m_cs;
         ps = m_sclk;
         pm = m_mosi;
         if (s) start_b = 1'b0;
         else begin
            start_a = ((p1 > 0) && (c == p1)) || ((p2 > 0) && (c == p2));
            if (start_a) tx_a = 8'hFF;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      tests_run++; if (busy_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      tests_run++; if (done_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done_a); end
      tests_run++; if (rx_a !== 8'h00)    begin tests_failed++; $display("FAIL reset_rx: got %h expected 00", rx_a); end
      tests_run++; if (sclk_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
      tests_run++; if (cs_a !== 1'b1)     begin tests_failed++; $display("FAIL reset_cs_n: got %b expected 1", cs_a); end
      tests_run++; if (mosi_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_mosi: got %b expected 0", mosi_a); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      miso_mode = 2'd2;
      xfer(1'b0, 8'hA5, 1'b0, 0, 0);
      tests_run++; if (mon_busy !== 34)     begin tests_failed++; $display("FAIL basic_busy_len: got %0d expected 34", mon_busy); end
      tests_run++; if (mon_nrise !== 8)     begin tests_failed++; $display("FAIL basic_rise_cnt: got %0d expected 8", mon_nrise); end
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (mon_rise[k] !== 2 + 4 * k) begin
            tests_failed++; $display("FAIL basic_rise_%0d: got %0d expected %0d", k, mon_rise[k], 2 + 4 * k);
         end
      end
      tests_run++; if (mon_mosi !== 8'hA5)  begin tests_failed++; $display("FAIL basic_mosi_seq: got %h expected a5", mon_mosi); end
      tests_run++; if (mon_hi_chg !== 0)    begin tests_failed++; $display("FAIL basic_mosi_stable: got %0d changes expected 0", mon_hi_chg); end
      tests_run++; if (mon_done_cnt !== 1)  begin tests_failed++; $display("FAIL basic_done_cnt: got %0d expected 1", mon_done_cnt); end
      tests_run++; if (mon_done_c !== 34)   begin tests_failed++; $display("FAIL basic_done_time: got %0d expected 34", mon_done_c); end
      tests_run++; if (mon_rx !== 8'hA5)    begin tests_failed++; $display("FAIL basic_rx: got %h expected a5", mon_rx); end
      tests_run++; if (mon_cs_bad !== 0)    begin tests_failed++; $display("FAIL basic_cs_low: got %0d high cycles expected 0", mon_cs_bad); end
      tests_run++; if (mon_cs_end !== 1'b1) begin tests_failed++; $display("FAIL basic_cs_after: got %b expected 1", mon_cs_end); end
   endtask

   task automatic test_fixed();
      int bad;
      miso_mode = 2'd1;
      xfer(1'b0, 8'h00, 1'b0, 0, 0);
      tests_run++; if (mon_rx !== 8'hFF) begin tests_failed++; $display("FAIL fixed_ones: got %h expected ff", mon_rx); end
      miso_mode = 2'd0;
      xfer(1'b0, 8'hFF, 1'b0, 0, 0);
      tests_run++; if (mon_rx !== 8'h00) begin tests_failed++; $display("FAIL fixed_zeros: got %h expected 00", mon_rx); end
      miso_mode = 2'd1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (rx_a !== 8'h00 || done_a !== 1'b0) bad++;
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL fixed_hold: got %0d disturbed cycles expected 0", bad); end
   endtask

   task automatic test_lsb_first();
      miso_mode = 2'd2;
      xfer(1'b1, 8'h3C, 1'b0, 0, 0);
      tests_run++; if (mon_busy !== 17)    begin tests_failed++; $display("FAIL lsb_busy_len: got %0d expected 17", mon_busy); end
      tests_run++; if (mon_mosi !== 8'h3C) begin tests_failed++; $display("FAIL lsb_mosi_seq: got %h expected 3c", mon_mosi); end
      tests_run++; if (mon_rise[0] !== 1 || mon_rise[7] !== 15) begin
         tests_failed++; $display("FAIL lsb_rise: got %0d,%0d expected 1,15", mon_rise[0], mon_rise[7]);
      end
      tests_run++; if (mon_done_c !== 17)  begin tests_failed++; $display("FAIL lsb_done_time: got %0d expected 17", mon_done_c); end
      tests_run++; if (mon_rx !== 8'h3C)   begin tests_failed++; $display("FAIL lsb_rx: got %h expected 3c", mon_rx); end
      mon_sel = 1'b0;
   endtask

   task automatic test_start_while_busy();
      miso_mode = 2'd2;
      xfer(1'b0, 8'h12, 1'b0, 5, 20);
      tests_run++; if (mon_mosi !== 8'h12)  begin tests_failed++; $display("FAIL busy_start_mosi: got %h expected 12", mon_mosi); end
      tests_run++; if (mon_done_cnt !== 1)  begin tests_failed++; $display("FAIL busy_start_done_cnt: got %0d expected 1", mon_done_cnt); end
      tests_run++; if (mon_rx !== 8'h12)    begin tests_failed++; $display("FAIL busy_start_rx: got %h expected 12", mon_rx); end
      tests_run++; if (mon_busy !== 34)     begin tests_failed++; $display("FAIL busy_start_len: got %0d expected 34", mon_busy); end
   endtask

   task automatic test_cs_hold();
      int         dones, cs_high, after;
      logic [7:0] rx2;
      bit         seen;
      miso_mode = 2'd2;
      dones = 0; cs_high = 0; after = -1; rx2 = 8'h00;
      @(negedge clock);
      start_a = 1'b1; tx_a = 8'h81; keep_a = 1'b1; rel_a = 1'b0;
      for (int c = 0; c < 120 && after < 6; c++) begin
         @(negedge clock);
         start_a = 1'b0;
         rel_a   = 1'b0;
         if (cs_a) cs_high++;
         if (done_a) begin
            dones++;
            rx2 = rx_a;
            if (dones == 1) begin start_a = 1'b1; tx_a = 8'h7E; keep_a = 1'b1; end
            else after = 0;
         end else if (after >= 0) after++;
         if (dones == 1 && busy_a && c == 50) rel_a = 1'b1;
      end
      tests_run++; if (dones !== 2)      begin tests_failed++; $display("FAIL cs_hold_dones: got %0d expected 2", dones); end
      tests_run++; if (cs_high !== 0)    begin tests_failed++; $display("FAIL cs_hold_low: got %0d high cycles expected 0", cs_high); end
      tests_run++; if (rx2 !== 8'h7E)    begin tests_failed++; $display("FAIL cs_hold_rx2: got %h expected 7e", rx2); end
      rel_a = 1'b1; keep_a = 1'b0;
      @(negedge clock);
      rel_a = 1'b0;
      tests_run++; if (cs_a !== 1'b1)    begin tests_failed++; $display("FAIL cs_release: got %b expected 1", cs_a); end
      start_a = 1'b1; rel_a = 1'b1; tx_a = 8'hC3; keep_a = 1'b0;
      @(negedge clock);
      start_a = 1'b0; rel_a = 1'b0;
      tests_run++; if (cs_a !== 1'b0 || busy_a !== 1'b1) begin
         tests_failed++; $display("FAIL cs_start_wins: got cs_n=%b busy=%b expected 0,1", cs_a, busy_a);
      end
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clock);
         if (done_a) seen = 1'b1;
      end
      tests_run++; if (!seen || rx_a !== 8'hC3 || cs_a !== 1'b1) begin
         tests_failed++; $display("FAIL cs_last_xfer: got done=%b rx=%h cs_n=%b expected 1,c3,1", seen, rx_a, cs_a);
      end
   endtask

   task automatic test_reset_mid();
      int dn;
      miso_mode = 2'd2;
      @(negedge clock);
      start_a = 1'b1; tx_a = 8'h33; keep_a = 1'b0;
      @(negedge clock);
      start_a = 1'b0;
      repeat (9) @(negedge clock);
      #1 reset_n = 1'b0;
      #1;
      tests_run++; if (sclk_a !== 1'b0 || cs_a !== 1'b1 || busy_a !== 1'b0 || mosi_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_pins: got sclk=%b cs_n=%b busy=%b mosi=%b expected 0,1,0,0", sclk_a, cs_a, busy_a, mosi_a);
      end
      tests_run++; if (rx_a !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_rx: got %h expected 00", rx_a); end
      dn = 0;
      repeat (2) begin @(negedge clock); if (done_a) dn++; end
      reset_n = 1'b1;
      repeat (4) begin @(negedge clock); if (done_a || busy_a) dn++; end
      tests_run++; if (dn !== 0) begin tests_failed++; $display("FAIL mid_reset_no_done: got %0d activity cycles expected 0", dn); end
      xfer(1'b0, 8'h5A, 1'b0, 0, 0);
      tests_run++; if (mon_rx !== 8'h5A)   begin tests_failed++; $display("FAIL post_reset_rx: got %h expected 5a", mon_rx); end
      tests_run++; if (mon_done_cnt !== 1) begin tests_failed++; $display("FAIL post_reset_done: got %0d expected 1", mon_done_cnt); end
      tests_run++; if (mon_busy !== 34)    begin tests_failed++; $display("FAIL post_reset_busy: got %0d expected 34", mon_busy); end
   endtask

   initial begin
      reset_n = 1'b0;
      start_a = 1'b0; tx_a = 8'h00; keep_a = 1'b0; rel_a = 1'b0;
      start_b = 1'b0; tx_b = 8'h00; keep_b = 1'b0; rel_b = 1'b0;
      miso_mode = 2'd0;
      mon_sel = 1'b0;
      test_reset();
      test_basic();
      test_fixed();
      test_lsb_first();
      test_start_while_busy();
      test_cs_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
